// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard control, condition-code register and halt/exception FSM
// for the five-stage Y86 pipeline.
// Optional build macro PIPE_CTRL_PERF_CNT_EN adds saturating performance
// counters (cycles, fetch stalls, execute bubbles). Without it the counter
// ports are tied to zero and no counter flops exist.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             halted,
  output logic [2:0]       exc_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [2:0] S_AOK   = 3'd1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic       w_loaduse;
  logic       w_ret_p;
  logic       w_mispred;
  logic       w_exc_mw;
  logic       w_w_bad;
  logic       w_m_bad;
  logic       r_halted;
  logic [2:0] r_exc_stat;
  logic       r_cc_zf;
  logic       r_cc_sf;
  logic       r_cc_of;

  // Hazard detection terms
  always_comb begin
    w_loaduse = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                (E_dstM != R_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    w_ret_p   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    w_mispred = (E_icode == I_JXX) && !e_cnd;
    w_m_bad   = (m_stat != S_AOK);
    w_w_bad   = (W_stat != S_AOK);
    w_exc_mw  = w_m_bad || w_w_bad;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: DRAIN is left only for HALTED, HALTED only by reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_w_bad) begin
          w_state_nxt = ST_HALTED;
        end else if (w_m_bad) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_w_bad) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: stall/bubble controls and CC write enable
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    if (r_state == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      F_stall  = w_loaduse | w_ret_p;
      D_stall  = w_loaduse;
      // Stall wins on D: a load/use hold must not be overwritten by a nop
      D_bubble = (w_mispred | (w_ret_p & ~w_loaduse)) & ~w_loaduse;
      E_bubble = w_mispred | w_loaduse;
      M_bubble = w_exc_mw;
      W_stall  = w_w_bad;
      set_cc   = (E_icode == I_OPQ) && !w_exc_mw;
    end
  end

  // Condition-code register, loaded from the execute-stage ALU flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc_zf <= 1'b1;
      r_cc_sf <= 1'b0;
      r_cc_of <= 1'b0;
    end else if (set_cc) begin
      r_cc_zf <= alu_zf;
      r_cc_sf <= alu_sf;
      r_cc_of <= alu_of;
    end
  end

  // Halt flag and exception status, captured on entry to HALTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted   <= 1'b0;
      r_exc_stat <= S_AOK;
    end else if ((r_state != ST_HALTED) && (w_state_nxt == ST_HALTED)) begin
      r_halted   <= 1'b1;
      r_exc_stat <= W_stat;
    end
  end

  assign cc_zf    = r_cc_zf;
  assign cc_sf    = r_cc_sf;
  assign cc_of    = r_cc_of;
  assign halted   = r_halted;
  assign exc_stat = r_exc_stat;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_active;

  assign w_active = (r_state != ST_HALTED);

  // Saturating performance counters, frozen once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (w_active) begin
      if (r_cyc_cnt != '1) begin
        r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
      end
      if (F_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (E_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign cyc_cnt    = r_cyc_cnt;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign cyc_cnt    = '0;
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/CC/halt scenarios plus
// randomized traffic, all compared against a behavioural model of the rules.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic             e_cnd, alu_zf, alu_sf, alu_of;
  logic [2:0]       m_stat, W_stat;
  logic             F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
  logic             cc_zf, cc_sf, cc_of, halted;
  logic [2:0]       exc_stat;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, bubble_cnt;

  int errors = 0;
  int checks = 0;

  // Model state (RUN and DRAIN look identical at the outputs)
  bit       m_halted;
  logic [2:0] m_exc;
  logic [2:0] m_cc;
  int       m_cyc, m_stall, m_bub;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .halted(halted), .exc_stat(exc_stat),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Expected {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc}
  function automatic logic [6:0] model_comb();
    bit lu, rp, mp, ex;
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_cnd;
    ex = (m_stat != 3'd1) || (W_stat != 3'd1);
    if (m_halted) return 7'b1110110;
    return {lu | rp, lu, W_stat != 3'd1, lu ? 1'b0 : (mp | rp), mp | lu, ex,
            (E_icode == 4'd6) && !ex};
  endfunction

  function automatic int sat_inc(int v);
    return (v < SAT) ? v + 1 : SAT;
  endfunction

  task automatic set_idle();
    D_icode = 4'd1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'd1; E_dstM = 4'hF; e_cnd = 1'b0;
    alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
    M_icode = 4'd1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_exc = 3'd1; m_cc = 3'b100;
    m_cyc = 0; m_stall = 0; m_bub = 0;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT
  task automatic tick();
    logic [6:0] v;
    v = model_comb();
    if (!m_halted) begin
      m_cyc = sat_inc(m_cyc);
      if (v[6]) m_stall = sat_inc(m_stall);
      if (v[2]) m_bub = sat_inc(m_bub);
      if (v[0]) m_cc = {alu_zf, alu_sf, alu_of};
      if (W_stat != 3'd1) begin
        m_halted = 1'b1;
        m_exc = W_stat;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({halted, exc_stat, cc_zf, cc_sf, cc_of} !== {m_halted, m_exc, m_cc}) begin
      errors++;
      $display("FAIL reset_regs: got %b want %b", {halted, exc_stat, cc_zf, cc_sf, cc_of},
               {m_halted, m_exc, m_cc});
    end
    checks++;
    if ({cyc_cnt, stall_cnt, bubble_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %h/%h/%h want 0", cyc_cnt, stall_cnt, bubble_cnt);
    end
    release_reset();
    #1;
    checks++;
    if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b",
               {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
    end
    tick();
  endtask

  task automatic test_loaduse();
    logic [3:0] tab_e [4] = '{4'd5, 4'd5, 4'd11, 4'd11};
    logic [3:0] tab_d [4] = '{4'd3, 4'd3, 4'd2, 4'hF};
    logic [3:0] tab_a [4] = '{4'd3, 4'd4, 4'd7, 4'hF};
    logic [3:0] tab_b [4] = '{4'hF, 4'd5, 4'd2, 4'hF};
    for (int i = 0; i < 4; i++) begin
      set_idle();
      E_icode = tab_e[i]; E_dstM = tab_d[i]; d_srcA = tab_a[i]; d_srcB = tab_b[i];
      #1;
      checks++;
      if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
        errors++;
        $display("FAIL loaduse_%0d: got %b want %b", i,
                 {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
      end
      tick();
    end
  endtask

  task automatic test_mispred();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      E_icode = 4'd7; e_cnd = (i == 1);
      #1;
      checks++;
      if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
        errors++;
        $display("FAIL mispred_cnd%0d: got %b want %b", i,
                 {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
      end
      tick();
    end
  endtask

  task automatic test_ret();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: D_icode = 4'd9;
        1: E_icode = 4'd9;
        2: M_icode = 4'd9;
        default: begin
          D_icode = 4'd9; E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        end
      endcase
      #1;
      checks++;
      if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
        errors++;
        $display("FAIL ret_step%0d: got %b want %b", i,
                 {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
      end
      tick();
    end
  endtask

  task automatic test_cc();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      E_icode = 4'd6;
      {alu_zf, alu_sf, alu_of} = (i == 0) ? 3'b011 : 3'b100;
      m_stat = (i == 0) ? 3'd1 : 3'd3;
      #1;
      checks++;
      if (set_cc !== model_comb()[0]) begin
        errors++;
        $display("FAIL cc_set%0d: got %b want %b", i, set_cc, model_comb()[0]);
      end
      tick();
      checks++;
      if ({cc_zf, cc_sf, cc_of} !== m_cc) begin
        errors++;
        $display("FAIL cc_val%0d: got %b want %b", i, {cc_zf, cc_sf, cc_of}, m_cc);
      end
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      if (i == 0) m_stat = 3'd2;
      if (i == 1) W_stat = 3'd2;
      if (i >= 2) begin
        E_icode = 4'd6; {alu_zf, alu_sf, alu_of} = 3'b101; D_icode = 4'd7;
      end
      #1;
      checks++;
      if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
        errors++;
        $display("FAIL halt_ctrl%0d: got %b want %b", i,
                 {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
      end
      checks++;
      if ({halted, exc_stat, cc_zf, cc_sf, cc_of} !== {m_halted, m_exc, m_cc}) begin
        errors++;
        $display("FAIL halt_regs%0d: got %b want %b", i, {halted, exc_stat, cc_zf, cc_sf, cc_of},
                 {m_halted, m_exc, m_cc});
      end
      tick();
    end
    // Asynchronous reset mid-cycle, away from any rising edge
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({halted, exc_stat, cc_zf, cc_sf, cc_of} !== {m_halted, m_exc, m_cc}) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", {halted, exc_stat, cc_zf, cc_sf, cc_of},
               {m_halted, m_exc, m_cc});
    end
    set_idle();
    release_reset();
  endtask

  task automatic test_random(input int n, input int bad_pct);
    for (int i = 0; i < n; i++) begin
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      E_dstM  = 4'($urandom_range(0, 15));
      d_srcA  = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
      d_srcB  = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
      e_cnd   = 1'($urandom_range(0, 1));
      {alu_zf, alu_sf, alu_of} = 3'($urandom_range(0, 7));
      m_stat  = (int'($urandom_range(0, 99)) < bad_pct) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = (int'($urandom_range(0, 99)) < bad_pct / 4) ? 3'($urandom_range(2, 4)) : 3'd1;
      #1;
      checks++;
      if ({F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc} !== model_comb()) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got %b want %b", i,
                 {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}, model_comb());
      end
      checks++;
      if ({halted, exc_stat, cc_zf, cc_sf, cc_of} !== {m_halted, m_exc, m_cc}) begin
        errors++;
        $display("FAIL rand_regs@%0d: got %b want %b", i, {halted, exc_stat, cc_zf, cc_sf, cc_of},
                 {m_halted, m_exc, m_cc});
      end
      tick();
    end
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] e_cyc, e_stl, e_bub;
    @(negedge clk);
    set_idle();
    #2 rst_n = 1'b0;
    model_reset();
    release_reset();
    for (int i = 0; i < 20; i++) begin
      set_idle();
      E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
      tick();
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    e_cyc = m_cyc[CNT_W-1:0]; e_stl = m_stall[CNT_W-1:0]; e_bub = m_bub[CNT_W-1:0];
`else
    e_cyc = '0; e_stl = '0; e_bub = '0;
`endif
    checks++;
    if (cyc_cnt !== e_cyc) begin
      errors++;
      $display("FAIL perf_cyc: got %0d want %0d", cyc_cnt, e_cyc);
    end
    checks++;
    if (stall_cnt !== e_stl) begin
      errors++;
      $display("FAIL perf_stall: got %0d want %0d", stall_cnt, e_stl);
    end
    checks++;
    if (bubble_cnt !== e_bub) begin
      errors++;
      $display("FAIL perf_bubble: got %0d want %0d", bubble_cnt, e_bub);
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_loaduse();
    test_mispred();
    test_ret();
    test_cc();
    test_halt();
    test_random(300, 0);
    test_reset();
    test_random(200, 8);
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 pipeline.
- Produces the stall and bubble signals for the F/D/E/M/W pipeline registers from load/use, ret and mispredicted-jump hazards.
- Owns the architectural condition-code register fed by the execute-stage ALU flags, and gates CC updates (set_cc) on exceptions.
- Runs a halt/exception state machine that freezes the pipe once a non-AOK status reaches write-back.

Parameters:
- CNT_W, 32, width of performance counters (only used with PERF_CNT_EN).

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- D_icode  input  4  icode in decode register.
- d_srcA  input  4  decode source A (0xF = none).
- d_srcB  input  4  decode source B (0xF = none).
- E_icode  input  4  icode in execute register.
- E_dstM  input  4  execute-stage memory destination register.
- e_cnd  input  1  condition result from execute.
- alu_zf, alu_sf, alu_of  input  1 each  raw ALU flags from execute.
- M_icode  input  4  icode in memory register.
- m_stat  input  3  memory-stage status (post-access).
- W_stat  input  3  write-back status.
- F_stall, D_stall, W_stall  output  1 each  hold the pipeline register.
- D_bubble, E_bubble, M_bubble  output  1 each  load a nop into the pipeline register.
- set_cc  output  1  CC register updates this cycle.
- cc_zf, cc_sf, cc_of  output  1 each  registered condition codes.
- halted  output  1  pipeline frozen.
- exc_stat  output  3  status latched on halt.
- cyc_cnt, stall_cnt, bubble_cnt  output  CNT_W each  performance counters (PERF_CNT_EN only).

Behaviour:
- Encodings: icodes HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B. Status AOK=1, HLT=2, ADR=3, INS=4. RNONE=0xF.
- Hazard terms (combinational):
  - loaduse = E_icode∈{MRMOV,POP} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - ret_p = RET ∈ {D_icode, E_icode, M_icode}.
  - mispred = E_icode==JXX && !e_cnd.
  - exc_mw = m_stat!=AOK || W_stat!=AOK.
- Outputs in RUN and DRAIN:
  - F_stall = loaduse | ret_p.
  - D_stall = loaduse.
  - D_bubble = mispred | (ret_p & ~loaduse).
  - E_bubble = mispred | loaduse.
  - M_bubble = exc_mw.
  - W_stall = W_stat!=AOK.
- Never assert stall and bubble on the same register together; D_stall has priority over D_bubble.
- set_cc = E_icode==OPQ && !exc_mw && state!=HALTED.
- CC register:
  - On posedge clk, if set_cc: cc_zf/sf/of <= alu_zf/sf/of.
  - Otherwise hold.
  - Reset values: cc_zf=1, cc_sf=0, cc_of=0.
- FSM states RUN, DRAIN, HALTED; reset to RUN.
  - RUN: W_stat!=AOK → HALTED; else m_stat!=AOK → DRAIN.
  - DRAIN: W_stat!=AOK → HALTED. m_stat returning to AOK does not leave DRAIN (the exception is already in flight).
  - HALTED: sticky until rst_n low.
  - On entry to HALTED: exc_stat <= W_stat.
- In HALTED:
  - F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1, D_bubble = 0, set_cc = 0.
  - halted = 1 (registered; asserted the cycle after the transition edge).
- Reset values: halted=0, exc_stat=AOK(1), CC as above, counters 0.
- Stall/bubble outputs are combinational from inputs and state; no added latency.
- Asynchronous reset mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle while not HALTED.
  - stall_cnt increments on cycles with F_stall=1 in RUN or DRAIN.
  - bubble_cnt increments on cycles with E_bubble=1 in RUN or DRAIN.
  - All three saturate at 2^CNT_W−1 and clear on reset.
- Undefined: the counter ports still exist and are tied to 0; no counter flops are built.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0 for exactly that cycle. Same with d_srcA=4, d_srcB=5 → all 0.
- Mispredict: E_icode=7, e_cnd=0 → D_bubble=1, E_bubble=1, F_stall=0. With e_cnd=1 → all 0.
- Ret sequence: RET walks D→E→M over 3 cycles → F_stall=1 and D_bubble=1 each of the 3 cycles. Combined with loaduse in D → D_stall=1, D_bubble=0.
- CC update:
  - E_icode=6, alu_zf=0, alu_sf=1, alu_of=1, stats AOK → after edge cc=(0,1,1).
  - Repeat with m_stat=3 → set_cc=0, cc unchanged.
- Halt flow: m_stat=2 one cycle (→DRAIN), next cycle W_stat=2 → HALTED, halted=1, exc_stat=2, all stalls/bubbles frozen. Pulse rst_n=0 asynchronously mid-cycle → halted=0, cc=(1,0,0) immediately.
- PIPE_CTRL_PERF_CNT_EN build, CNT_W=4: 20 cycles of continuous loaduse → stall_cnt saturates at 15, cyc_cnt=15. Non-EN build → counters read 0.
